// File: rtl/prog3_pkg.sv
// ----------------------------------------------------------------------------
// prog3_pkg : shared states, addresses and helpers for the program-3 engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package prog3_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SCAN = 3'd2,
    S_WR33 = 3'd3,
    S_WR34 = 3'd4,
    S_WR35 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [7:0] PAT_ADDR = 8'd32;
  localparam logic [7:0] CTB_ADDR = 8'd33;
  localparam logic [7:0] CTO_ADDR = 8'd34;
  localparam logic [7:0] CTS_ADDR = 8'd35;
  localparam logic [7:0] MSG_LEN  = 8'd32;

  function automatic logic [7:0] popcnt4(input logic [3:0] v);
    return {7'd0, v[0]} + {7'd0, v[1]} + {7'd0, v[2]} + {7'd0, v[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_match5.sv
// ----------------------------------------------------------------------------
// pattern_match5 : 5-bit window compare over a {previous, current} byte pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pattern_match5 (
  input  logic [15:0] pair,
  input  logic [4:0]  pat,
  output logic [3:0]  in_match,
  output logic [3:0]  cross_match
);

  // in_match[k]: current byte bits [7-k:3-k]; cross_match[j]: window at
  // MSB offset 4+j of the previous byte, spilling into the current byte.
  for (genvar k = 0; k < 4; k++) begin : g_win
    assign in_match[k]    = (pair[7-k -: 5]  == pat);
    assign cross_match[k] = (pair[11-k -: 5] == pat);
  end

endmodule

`default_nettype wire

// File: rtl/prog3_dmem.sv
// ----------------------------------------------------------------------------
// prog3_dmem : 256x8 data memory, asynchronous read, synchronous write
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prog3_dmem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end

  assign rdata = core[raddr];

endmodule

`default_nettype wire

// File: rtl/prog3_regfile.sv
// ----------------------------------------------------------------------------
// prog3_regfile : 8x8 register file with per-register write enables
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prog3_regfile (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      we,
  input  logic [7:0][7:0] wd,
  output logic [7:0][7:0] rd
);

  logic [7:0] core [0:7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) core[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (we[i]) core[i] <= wd[i];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_rd
    assign rd[i] = core[i];
  end

endmodule

`default_nettype wire

// File: rtl/prog3_pattern_engine.sv
// ----------------------------------------------------------------------------
// prog3_pattern_engine : hardwired sequencer counting 5-bit pattern matches
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prog3_pattern_engine
  import prog3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);

  state_t          state_q, state_d;
  logic [7:0]      prog_ctr, prog_ctr_d;
  logic [7:0]      rf_we;
  logic [7:0][7:0] rf_wd, rf_rd;
  logic            dm_we;
  logic [7:0]      dm_waddr, dm_wdata, dm_raddr, dm_rdata;
  logic [3:0]      in_match, cross_match;
  logic [7:0]      ctb_add, cts_add;
  logic            unused_bits;

  prog3_dmem dm1 (
    .clk   (clk),
    .we    (dm_we),
    .waddr (dm_waddr),
    .wdata (dm_wdata),
    .raddr (dm_raddr),
    .rdata (dm_rdata)
  );

  prog3_regfile rf1 (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .wd    (rf_wd),
    .rd    (rf_rd)
  );

  pattern_match5 u_match (
    .pair        ({rf_rd[5], dm_rdata}),
    .pat         (rf_rd[0][4:0]),
    .in_match    (in_match),
    .cross_match (cross_match)
  );

  // Byte 0 has no predecessor, so its cross windows are suppressed.
  assign ctb_add = popcnt4(in_match);
  assign cts_add = ctb_add + ((rf_rd[1] != 8'd0) ? popcnt4(cross_match) : 8'd0);
  assign done    = (state_q == S_DONE);
  assign unused_bits = ^{rf_rd[0][7:5], rf_rd[6], rf_rd[7]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      prog_ctr <= '0;
    end else begin
      state_q  <= state_d;
      prog_ctr <= prog_ctr_d;
    end
  end

  // Each state names the step completed at the edge that entered it; the
  // work done at the next edge is selected here from the current state.
  always_comb begin
    state_d    = state_q;
    prog_ctr_d = (state_q == S_DONE) ? prog_ctr : prog_ctr + 8'd1;
    rf_we      = '0;
    rf_wd      = '0;
    dm_we      = 1'b0;
    dm_waddr   = CTB_ADDR;
    dm_wdata   = '0;
    dm_raddr   = rf_rd[1];
    case (state_q)
      S_IDLE: begin
        dm_raddr  = PAT_ADDR;
        rf_we     = 8'hFF;
        rf_wd[0]  = {3'b000, dm_rdata[7:3]};
        state_d   = S_LOAD;
      end
      S_LOAD, S_SCAN: begin
        if (rf_rd[1] == MSG_LEN) begin
          dm_we    = 1'b1;
          dm_waddr = CTB_ADDR;
          dm_wdata = rf_rd[2];
          state_d  = S_WR33;
        end else begin
          rf_we    = 8'hFE;
          rf_wd[1] = rf_rd[1] + 8'd1;
          rf_wd[2] = rf_rd[2] + ctb_add;
          rf_wd[3] = rf_rd[3] + {7'd0, |in_match};
          rf_wd[4] = rf_rd[4] + cts_add;
          rf_wd[5] = dm_rdata;
          rf_wd[6] = dm_rdata;
          rf_wd[7] = {cross_match, in_match};
          state_d  = S_SCAN;
        end
      end
      S_WR33: begin
        dm_we    = 1'b1;
        dm_waddr = CTO_ADDR;
        dm_wdata = rf_rd[3];
        state_d  = S_WR34;
      end
      S_WR34: begin
        dm_we    = 1'b1;
        dm_waddr = CTS_ADDR;
        dm_wdata = rf_rd[4];
        state_d  = S_WR35;
      end
      S_WR35:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_prog3_pattern_engine.sv
// ----------------------------------------------------------------------------
// tb_prog3_pattern_engine : directed self-checking bench for the engine top
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_prog3_pattern_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;
  int   n_cmp = 0;
  int   n_bad = 0;

  prog3_pattern_engine dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Memory is only touched while the engine sits in reset.
  task automatic preload(input logic [4:0] p, input logic [7:0] fill);
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = fill;
    dut.dm1.core[32] = {p, 3'b101};
    dut.dm1.core[33] = 8'hEE;
    dut.dm1.core[34] = 8'hEE;
    dut.dm1.core[35] = 8'hEE;
  endtask

  task automatic run_to_done(output int edges);
    edges = -1;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic rf_ok;
    dut.dm1.core[33] = 8'hA5;
    hold_reset();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done got %0b want 0", done);
    end
    n_cmp++;
    if (dut.prog_ctr !== 8'd0) begin
      n_bad++; $display("FAIL reset_prog_ctr got %0d want 0", dut.prog_ctr);
    end
    rf_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (dut.rf1.core[i] !== 8'd0) rf_ok = 1'b0;
    n_cmp++;
    if (rf_ok !== 1'b1) begin
      n_bad++; $display("FAIL reset_rf got nonzero want all zero");
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut.dm1.core[33] !== 8'hA5) begin
      n_bad++; $display("FAIL reset_mem33 got %h want a5", dut.dm1.core[33]);
    end
  endtask

  task automatic test_case(input string name, input logic [4:0] p,
                           input logic [7:0] fill, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b31,
                           input logic [7:0] ctb, input logic [7:0] cto,
                           input logic [7:0] cts);
    int edges;
    hold_reset();
    preload(p, fill);
    dut.dm1.core[0]  = b0;
    dut.dm1.core[1]  = b1;
    dut.dm1.core[31] = b31;
    run_to_done(edges);
    n_cmp++;
    if (edges !== 37) begin
      n_bad++; $display("FAIL %s done_edge got %0d want 37", name, edges);
    end
    n_cmp++;
    if (dut.dm1.core[33] !== ctb) begin
      n_bad++; $display("FAIL %s ctb got %0d want %0d", name, dut.dm1.core[33], ctb);
    end
    n_cmp++;
    if (dut.dm1.core[34] !== cto) begin
      n_bad++; $display("FAIL %s cto got %0d want %0d", name, dut.dm1.core[34], cto);
    end
    n_cmp++;
    if (dut.dm1.core[35] !== cts) begin
      n_bad++; $display("FAIL %s cts got %0d want %0d", name, dut.dm1.core[35], cts);
    end
  endtask

  task automatic test_done_hold();
    int edges;
    hold_reset();
    preload(5'b00000, 8'h00);
    run_to_done(edges);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL hold_done got %0b want 1", done);
    end
    n_cmp++;
    if (dut.prog_ctr !== 8'd37) begin
      n_bad++; $display("FAIL hold_prog_ctr got %0d want 37", dut.prog_ctr);
    end
  endtask

  task automatic test_mid_reset();
    int edges;
    hold_reset();
    preload(5'b11111, 8'h00);
    dut.dm1.core[5]  = 8'hFF;
    dut.dm1.core[33] = 8'h11;
    dut.dm1.core[34] = 8'h22;
    dut.dm1.core[35] = 8'h33;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL mid_done got %0b want 0", done);
    end
    n_cmp++;
    if (dut.prog_ctr !== 8'd0) begin
      n_bad++; $display("FAIL mid_prog_ctr got %0d want 0", dut.prog_ctr);
    end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if ({dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]} !== 24'h112233) begin
      n_bad++; $display("FAIL mid_mem got %h%h%h want 112233",
                        dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
    end
    run_to_done(edges);
    n_cmp++;
    if (edges !== 37) begin
      n_bad++; $display("FAIL mid_rerun_edge got %0d want 37", edges);
    end
    n_cmp++;
    if ({dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]} !== {8'd4, 8'd1, 8'd4}) begin
      n_bad++; $display("FAIL mid_rerun_counts got %0d/%0d/%0d want 4/1/4",
                        dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
    end
  endtask

  initial begin
    test_reset();
    test_case("zeros",     5'b00000, 8'h00, 8'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
    test_case("ones",      5'b11111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd128, 8'd32, 8'd252);
    test_case("alt55",     5'b10101, 8'h55, 8'h55, 8'h55, 8'h55, 8'd64,  8'd32, 8'd126);
    test_case("nomatch",   5'b00000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0,   8'd0,  8'd0);
    test_case("b0_f8",     5'b11111, 8'h00, 8'hF8, 8'h00, 8'h00, 8'd1,   8'd1,  8'd1);
    test_case("cross",     5'b11111, 8'h00, 8'h03, 8'hE0, 8'h00, 8'd0,   8'd0,  8'd1);
    test_case("b31_1f",    5'b11111, 8'h00, 8'h00, 8'h00, 8'h1F, 8'd1,   8'd1,  8'd1);
    test_done_hold();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog3_pattern_engine.md
# prog3_pattern_engine

Hardwired sequencer top for program 3 (5-bit pattern search over a 32-byte message). On reset release it reads the pattern and message from its internal data memory and computes three match counts. It writes the counts back to data memory and raises `done`. It is the DUT top, with no I/O beyond clock, reset and `done`. Internal state is exposed through fixed hierarchical names for bench preload and monitoring.

## Interface
- No parameters.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset; releasing it (rising edge) starts a run.
- `done`  output  1  high when results are written; held until the next reset assertion.
- Required hierarchy:
  - `dm1.core[0:255]`: 8-bit data memory, asynchronous read, synchronous write, not cleared by reset.
  - `rf1.core[0:7]`: 8-bit register file.
  - `prog_ctr`: 8-bit step counter.

## Operation
- Inputs (bench preloaded):
  - Message bytes are `dm1.core[0..31]`.
  - Pattern P = `dm1.core[32][7:3]`.
- Message string S is 256 bits: byte 0 is most significant, and bit 7 of each byte comes first.
- Outputs, all 8-bit:
  - `dm1.core[33]` = CTB: number of (byte, k) pairs, byte 0..31 and k 0..3, where byte[7-k:3-k] == P. Maximum 128.
  - `dm1.core[34]` = CTO: number of bytes with at least one in-byte match. Maximum 32.
  - `dm1.core[35]` = CTS: number of 5-bit windows of S, starting at MSB offsets 0..251, equal to P. These windows may cross byte boundaries. Maximum 252.
- Register usage:
  - r0: P, right-aligned.
  - r1: byte index.
  - r2: CTB.
  - r3: CTO.
  - r4: CTS.
  - r5: previous byte.
  - r6: current byte.
  - r7: scratch.
- States:
  - IDLE: held in reset.
  - LOAD: read `dm1.core[32]` into r0; clear r1–r7.
  - SCAN: one byte per cycle, index 0..31. Read byte i into r6 and add its 4 in-byte matches to CTB. Increment CTO if any in-byte match. Add the 4 in-byte windows of byte i to CTS. For i ≥ 1, also add the 4 cross windows of the pair {r5, byte i} (offsets 4..7 of byte i-1) to CTS. Copy byte i into r5.
  - WR33, WR34, WR35: write CTB, CTO, CTS respectively.
  - DONE: assert `done`; stay in DONE until reset.
- Cross windows of byte 31 into a nonexistent byte 32 are never counted.

## Timing
- Reset values: `done`=0, state IDLE, `prog_ctr`=0, `rf1.core` all 0. Memory is untouched.
- Cycle schedule, counting edges after reset release:
  - Edge 1: LOAD.
  - Edges 2–33: SCAN.
  - Edges 34–36: writes.
  - Edge 37: `done` rises.
- `prog_ctr` increments on every edge until DONE, then freezes.
- Reset asserted mid-run: all state clears immediately and no further memory writes occur. Locations 33–35 keep whatever they held. A full run restarts on release.
- Counters use 8-bit arithmetic; the value ranges above guarantee no wrap.

## Structure
- Shared package `prog3_pkg`:
  - state enum.
  - address constants: PAT_ADDR=32, CTB_ADDR=33, CTO_ADDR=34, CTS_ADDR=35, MSG_LEN=32.
- Sub-modules:
  - `dm1`: memory instance.
  - `rf1`: register file instance.
  - `pattern_match5`: combinational. Inputs are a 16-bit window pair and P. Outputs are the 4 in-byte match flags and the 4 cross-window match flags.

## Test plan
- P=00000, all bytes 0x00 -> CTB=128, CTO=32, CTS=252; `done` at edge 37.
- P=11111, all bytes 0xFF -> 128, 32, 252.
- P=10101, all bytes 0x55 -> CTB=64, CTO=32, CTS=126.
- P=00000, all bytes 0xFF -> 0, 0, 0.
- Boundary cases, P=11111 with remaining bytes 0x00:
  - byte0=0xF8 -> 1, 1, 1.
  - byte0=0x03, byte1=0xE0 -> 0, 0, 1 (cross-byte only).
  - byte31=0x1F -> CTB=1, CTO=1, CTS=1 (last in-byte window counted).
- Reset reasserted at SCAN byte 10 -> `done`=0 and `prog_ctr`=0 immediately, locations 33–35 unchanged. After release, a full run gives correct counts at edge 37.
